obi_bridge_initiator: RTL and testbench
=======================================

Name: obi_bridge_initiator

Overview:
- Host-side initiator for the bridge bus that the DUT top-level exposes as a responder (req/we/be/addr/wdata -> gnt/rvalid/rdata).
- Accepts one command at a time from the host register interface (CW305 USB/FPGA register logic or a testbench driver) and issues exactly one bus transaction.
- Holds the command stable until grant, then waits for rvalid and returns read data or error status through a response handshake.
- Instantiated beside the gr-heep top on the FPGA and in the testbench system, in place of direct pin driving.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT_CYC, 1024, cycles allowed per phase (grant wait, rvalid wait) before abort; used only with the optional feature

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  initiator idle, command accepted when valid&ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_be_i  in  DATA_W/8  byte enables
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  host consumes response
- rsp_rdata_o  out  DATA_W  read data (0 for writes)
- rsp_err_o  out  1  transaction timed out (0 without the optional feature)
- req_o  out  1  bus request
- we_o  out  1  bus write enable
- be_o  out  DATA_W/8  bus byte enables
- addr_o  out  ADDR_W  bus address
- wdata_o  out  DATA_W  bus write data
- gnt_i  in  1  bus grant
- rvalid_i  in  1  bus response valid
- rdata_i  in  DATA_W  bus read data

Behaviour:
- Reset (rst_i sampled high at a clk_i edge): state IDLE. req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. cmd_ready_o=1 from the first cycle after reset.
- Reset mid-transaction: abort immediately with no response produced. A late rvalid_i arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: cmd_ready_o=1.
  - On cmd_valid_i: register we/be/addr/wdata onto the bus outputs and go to REQ.
  - req_o rises in the cycle after acceptance. There is no combinational path from cmd_* to bus outputs.
- REQ: req_o=1; we/be/addr/wdata are held stable.
  - On gnt_i: req_o drops in the next cycle and the FSM goes to WAIT_R.
  - Minimum latency is acceptance -> req_o: 1 cycle.
- WAIT_R: req_o=0.
  - On rvalid_i: capture rdata_i if it is a read, otherwise capture 0. Set rsp_err_o=0 and go to RESP.
  - rvalid_i in the same cycle as gnt_i is not legal on this bus. It is ignored in REQ.
- RESP: rsp_valid_o=1, with rdata and err held stable.
  - On rsp_ready_i: rsp_valid_o drops in the next cycle and the FSM returns to IDLE.
  - cmd_ready_o stays 0 until then, so there is one outstanding transaction maximum.
- Best case for a read with a 1-cycle responder: accept(t0), req(t1), gnt(t1), rvalid(t2), rsp_valid(t3). Round trip is 3 cycles.
- Any rvalid_i outside WAIT_R (spurious) is ignored and does not change state.
- Byte enables of 0 are forwarded unmodified. Address bits are not realigned.
- cmd_* values arriving while cmd_ready_o=0 are ignored.

Optional Feature:
- Macro: OBI_BRIDGE_TIMEOUT_EN.
- Defined:
  - A saturating counter is cleared on entry to REQ and to WAIT_R, and increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYC-1 without gnt_i or rvalid_i, the block drops req_o, goes to RESP with rsp_err_o=1 and rsp_rdata_o=32'hDEAD_BEEF.
  - A later rvalid_i for the aborted transaction is ignored.
  - If the handshake arrives in the same cycle as expiry, the handshake wins and rsp_err_o=0.
- Undefined: no counter exists. The block waits indefinitely and rsp_err_o is tied to 0.

Decomposition:
- Package obi_bridge_pkg holds:
  - the state enum type (IDLE, REQ, WAIT_R, RESP)
  - a packed cmd struct (we, be, addr, wdata)
  - the constant TIMEOUT_RDATA = 32'hDEAD_BEEF
- One sub-module, obi_bridge_timeout_cnt, with inputs clear, enable and max, and output expired. It is instantiated only under OBI_BRIDGE_TIMEOUT_EN.

Test Plan:
- Write: cmd we=1, be=4'hF, addr=32'h0000_0100, wdata=32'hCAFE_0001. Responder grants immediately and asserts rvalid 1 cycle later. Required: one req_o pulse with matching fields, then rsp_valid_o=1, rsp_rdata_o=0, rsp_err_o=0.
- Read: read of addr=32'h0000_0100 with gnt delayed 5 cycles. Required: addr_o/we_o stable for all 6 req cycles. rdata_i=32'h1234_5678 is returned on rsp_rdata_o.
- Back-pressure: rsp_ready_i held low for 10 cycles after the response. Required: rsp_valid_o and rsp_rdata_o stay stable, cmd_ready_o=0, and a second cmd_valid_i is ignored until the response is consumed.
- Reset mid-transaction: rst_i pulsed high for 1 cycle while in WAIT_R. Required: all outputs return to reset values in the next cycle. The following rvalid_i produces no rsp_valid_o.
- Spurious rvalid: rvalid_i pulsed while IDLE. Required: no state change and no response produced.
- Timeout (with OBI_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=16): gnt_i is never asserted. Required: req_o drops after 16 cycles in REQ, rsp_err_o=1 and rsp_rdata_o=32'hDEAD_BEEF.

Source files
------------

// File: rtl/obi_bridge_pkg.sv
// rtl/obi_bridge_pkg.sv - shared types and constants for the OBI bridge initiator
package obi_bridge_pkg;

  localparam int BRIDGE_ADDR_W = 32;
  localparam int BRIDGE_DATA_W = 32;

  // Read data returned when a phase times out
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Command captured from the host and driven onto the bridge bus
  typedef struct packed {
    logic                       we;
    logic [BRIDGE_DATA_W/8-1:0] be;
    logic [BRIDGE_ADDR_W-1:0]   addr;
    logic [BRIDGE_DATA_W-1:0]   wdata;
  } cmd_t;

endpackage

// File: rtl/obi_bridge_timeout_cnt.sv
// rtl/obi_bridge_timeout_cnt.sv - saturating phase timer for the bridge initiator
module obi_bridge_timeout_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] max,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  // Count cycles spent in a waiting phase, holding at max
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != max)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = enable && (cnt_q == max);

endmodule

// File: rtl/obi_bridge_initiator.sv
// rtl/obi_bridge_initiator.sv - host-side bridge bus initiator; OBI_BRIDGE_TIMEOUT_EN adds phase timeouts
module obi_bridge_initiator
  import obi_bridge_pkg::*;
#(
  parameter int ADDR_W      = BRIDGE_ADDR_W,
  parameter int DATA_W      = BRIDGE_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [DATA_W/8-1:0] cmd_be_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                req_o,
  output logic                we_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic                gnt_i,
  input  logic                rvalid_i,
  input  logic [DATA_W-1:0]   rdata_i
);

  state_e            state_q, state_d;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              capture;
  logic [DATA_W-1:0] capture_rdata;
  logic              capture_err;
  logic              expired;

`ifdef OBI_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic cnt_clear;
  logic cnt_enable;

  // Timer restarts whenever the FSM moves, so each phase gets its own budget
  assign cnt_enable = (state_q == REQ) || (state_q == WAIT_R);
  assign cnt_clear  = (state_d != state_q);

  obi_bridge_timeout_cnt #(
    .W (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .max     (CNT_W'(TIMEOUT_CYC - 1)),
    .expired (expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign expired            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and response capture; handshakes take priority over expiry
  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    capture_rdata = '0;
    capture_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) state_d = REQ;
      end
      REQ: begin
        if (gnt_i) begin
          state_d = WAIT_R;
        end else if (expired) begin
          state_d       = RESP;
          capture       = 1'b1;
          capture_rdata = DATA_W'(TIMEOUT_RDATA);
          capture_err   = 1'b1;
        end
      end
      WAIT_R: begin
        if (rvalid_i) begin
          state_d       = RESP;
          capture       = 1'b1;
          capture_rdata = cmd_q.we ? '0 : rdata_i;
        end else if (expired) begin
          state_d       = RESP;
          capture       = 1'b1;
          capture_rdata = DATA_W'(TIMEOUT_RDATA);
          capture_err   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command and response registers; bus fields only change on acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && cmd_valid_i) begin
        cmd_q <= '{we: cmd_we_i, be: cmd_be_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
      end
      if (capture) begin
        rdata_q <= capture_rdata;
        err_q   <= capture_err;
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign req_o       = (state_q == REQ);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign we_o        = cmd_q.we;
  assign be_o        = cmd_q.be;
  assign addr_o      = cmd_q.addr;
  assign wdata_o     = cmd_q.wdata;

endmodule

// File: tb/tb_obi_bridge_initiator.sv
// tb/tb_obi_bridge_initiator.sv - self-checking bench for obi_bridge_initiator (OBI_BRIDGE_TIMEOUT_EN aware)
`timescale 1ns/1ps
module tb_obi_bridge_initiator;

  localparam int TC = 16;
`ifdef OBI_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  obi_bridge_initiator #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_be_i    (cmd_be),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .req_o       (req),
    .we_o        (we),
    .be_o        (be),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .gnt_i       (gnt),
    .rvalid_i    (rvalid),
    .rdata_i     (rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction, described by
  // whether it exists, has been granted and has a response ready.
  bit          model_ok = 1'b0;
  bit          t_active, t_granted, t_done;
  int          t_age;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;

  function automatic bit timed_out(input int age);
    return TO_EN && (age >= TC - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ok  <= 1'b1;
      t_active  <= 1'b0;
      t_granted <= 1'b0;
      t_done    <= 1'b0;
      t_age     <= 0;
      m_we <= 1'b0; m_be <= '0; m_addr <= '0; m_wdata <= '0;
      m_rdata <= '0; m_err <= 1'b0;
    end else if (!t_active) begin
      if (cmd_valid) begin
        t_active <= 1'b1; t_granted <= 1'b0; t_done <= 1'b0; t_age <= 0;
        m_we <= cmd_we; m_be <= cmd_be; m_addr <= cmd_addr; m_wdata <= cmd_wdata;
      end
    end else if (t_done) begin
      if (rsp_ready) t_active <= 1'b0;
    end else if (!t_granted) begin
      if (gnt) begin
        t_granted <= 1'b1; t_age <= 0;
      end else if (timed_out(t_age)) begin
        t_done <= 1'b1; m_err <= 1'b1; m_rdata <= 32'hDEAD_BEEF;
      end else begin
        t_age <= t_age + 1;
      end
    end else begin
      if (rvalid) begin
        t_done <= 1'b1; m_err <= 1'b0; m_rdata <= m_we ? 32'h0 : rdata;
      end else if (timed_out(t_age)) begin
        t_done <= 1'b1; m_err <= 1'b1; m_rdata <= 32'hDEAD_BEEF;
      end else begin
        t_age <= t_age + 1;
      end
    end
  end

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_cmd_ready", cmd_ready, !t_active);
      check("m_req", req, t_active && !t_granted && !t_done);
      check("m_rsp_valid", rsp_valid, t_active && t_done);
      check("m_we", we, m_we);
      check("m_be", be, m_be);
      check("m_addr", addr, m_addr);
      check("m_wdata", wdata, m_wdata);
      check("m_rsp_rdata", rsp_rdata, m_rdata);
      check("m_rsp_err", rsp_err, m_err);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_be = '0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_we = w; cmd_be = 4'hF; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_req", req, 1'b0);
    check("rst_addr", addr, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);

    // Write, immediate grant, rvalid one cycle later
    issue(1'b1, 32'h0000_0100, 32'hCAFE_0001);
    check("wr_req", req, 1'b1);
    check("wr_we", we, 1'b1);
    check("wr_be", be, 4'hF);
    check("wr_addr", addr, 32'h0000_0100);
    check("wr_wdata", wdata, 32'hCAFE_0001);
    check("wr_cmd_ready", cmd_ready, 1'b0);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check("wr_req_single", req, 1'b0);
    rvalid = 1'b1; rdata = 32'h5555_AAAA;
    @(negedge clk);
    rvalid = 1'b0;
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_rsp_err", rsp_err, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("wr_rsp_done", rsp_valid, 1'b0);
    check("wr_ready_back", cmd_ready, 1'b1);

    // Read, grant on the sixth request cycle
    issue(1'b0, 32'h0000_0100, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check("rd_req_held", req, 1'b1);
      check("rd_addr_held", addr, 32'h0000_0100);
      check("rd_we_held", we, 1'b0);
      if (i == 5) gnt = 1'b1;
      @(negedge clk);
    end
    gnt = 1'b0;
    check("rd_req_drop", req, 1'b0);
    rvalid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    rvalid = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);

    // Back-pressure with a competing command
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_req", req, 1'b0);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0200;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_consumed", rsp_valid, 1'b0);
    check("bp_ready", cmd_ready, 1'b1);
    check("bp_addr_kept", addr, 32'h0000_0100);

    // Reset while waiting for rvalid
    issue(1'b0, 32'h0000_0300, 32'h0);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_req", req, 1'b0);
    check("mr_addr", addr, 32'h0);
    check("mr_we", we, 1'b0);
    check("mr_be", be, 4'h0);
    check("mr_wdata", wdata, 32'h0);
    check("mr_rsp_valid", rsp_valid, 1'b0);
    check("mr_rsp_rdata", rsp_rdata, 32'h0);
    check("mr_rsp_err", rsp_err, 1'b0);
    check("mr_cmd_ready", cmd_ready, 1'b1);
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    rvalid = 1'b0;
    check("mr_late_rvalid", rsp_valid, 1'b0);
    check("mr_late_ready", cmd_ready, 1'b1);

    // Spurious rvalid while idle
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = 32'hFFFF_0000;
      @(negedge clk);
      check("sp_ready", cmd_ready, 1'b1);
      check("sp_rsp_valid", rsp_valid, 1'b0);
      check("sp_req", req, 1'b0);
    end
    rvalid = 1'b0;

    // Grant never arrives
    issue(1'b0, 32'h0000_0400, 32'h0);
    n = 0;
    while (req && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (TO_EN) begin
      check("to_req_cycles", n, TC);
      check("to_rsp_valid", rsp_valid, 1'b1);
      check("to_rsp_err", rsp_err, 1'b1);
      check("to_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      rvalid = 1'b1;
      @(negedge clk);
      rvalid = 1'b0;
      check("to_late_rvalid", rsp_valid, 1'b0);
    end else begin
      check("nto_req_waits", n, 40);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      rvalid = 1'b1; rdata = 32'h0000_00A5;
      @(negedge clk);
      rvalid = 1'b0;
      check("nto_rsp_err", rsp_err, 1'b0);
      check("nto_rsp_rdata", rsp_rdata, 32'h0000_00A5);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_we    = ($urandom_range(0, 1) == 1);
      cmd_be    = 4'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      gnt       = (t_active && !t_granted && !t_done) ? ($urandom_range(0, 9) < 3) : 1'b0;
      if (t_active && t_granted && !t_done)
        rvalid = ($urandom_range(0, 9) < 4);
      else
        rvalid = ($urandom_range(0, 19) == 0);
      rdata     = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 4);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
